// File: rtl/i2c_slave_core.sv
// I2C target engine: synchronized SCL/SDA sampling, 7-bit address match, byte RX/TX through
// FIFO-style handshakes, with optional clock stretching while the TX FIFO is empty.
module i2c_slave_core #(
    parameter int SYNC_STAGES = 2,
    parameter bit STRETCH_EN  = 1'b1
) (
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic       en,
    input  logic [6:0] own_addr,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       scl_o,
    output logic       sda_o,
    input  logic [7:0] tx_data,
    input  logic       tx_empty,
    output logic       tx_rd,
    output logic [7:0] rx_data,
    input  logic       rx_full,
    output logic       rx_wr,
    output logic       busy,
    output logic       rw,
    output logic       addr_hit,
    output logic       stop_det,
    output logic       nack_det
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_ADDR      = 4'd1;
    localparam logic [3:0] S_ADDR_ACK  = 4'd2;
    localparam logic [3:0] S_RX_BYTE   = 4'd3;
    localparam logic [3:0] S_RX_ACK    = 4'd4;
    localparam logic [3:0] S_TX_LOAD   = 4'd5;
    localparam logic [3:0] S_TX_BYTE   = 4'd6;
    localparam logic [3:0] S_TX_ACK    = 4'd7;
    localparam logic [3:0] S_WAIT_STOP = 4'd8;

    logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
    logic                   r_scl_d, r_sda_d;
    logic                   w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

    // Synchronizers reset to the idle-bus level so reset release never looks like an edge.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
            r_scl_d    <= r_scl_sync[SYNC_STAGES-1];
            r_sda_d    <= r_sda_sync[SYNC_STAGES-1];
        end
    end

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[SYNC_STAGES-1];
    assign w_scl_rise = w_scl & ~r_scl_d;
    assign w_scl_fall = ~w_scl & r_scl_d;
    assign w_start    = r_scl_d & w_scl & r_sda_d & ~w_sda;
    assign w_stop     = r_scl_d & w_scl & ~r_sda_d & w_sda;

    logic [3:0] r_state;
    logic [6:0] r_shift;
    logic [2:0] r_bitcnt;
    logic       r_done, r_ack_on, r_nack, r_stretch;
    logic [2:0] r_setup;
    logic [7:0] w_byte;
    logic       w_last, w_load;

    assign w_byte = {r_shift, w_sda};
    assign w_last = (r_bitcnt == 3'd7);
    // The fall that ends an ACK slot toward a read either loads the next byte or starts stretching.
    assign w_load = w_scl_fall &&
                    ((r_state == S_ADDR_ACK && r_ack_on && rw) ||
                     (r_state == S_TX_LOAD && !r_stretch));

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_bitcnt  <= '0;
            r_done    <= 1'b0;
            r_ack_on  <= 1'b0;
            r_nack    <= 1'b0;
            r_stretch <= 1'b0;
            r_setup   <= '0;
            scl_o     <= 1'b1;
            sda_o     <= 1'b1;
            tx_rd     <= 1'b0;
            rx_wr     <= 1'b0;
            rx_data   <= 8'h00;
            busy      <= 1'b0;
            rw        <= 1'b0;
            addr_hit  <= 1'b0;
            stop_det  <= 1'b0;
            nack_det  <= 1'b0;
        end else begin
            tx_rd    <= 1'b0;
            rx_wr    <= 1'b0;
            addr_hit <= 1'b0;
            stop_det <= 1'b0;
            nack_det <= 1'b0;
            if (w_start) begin
                r_state   <= S_ADDR;
                r_bitcnt  <= '0;
                r_done    <= 1'b0;
                r_ack_on  <= 1'b0;
                r_stretch <= 1'b0;
                r_setup   <= '0;
                busy      <= 1'b1;
                scl_o     <= 1'b1;
                sda_o     <= 1'b1;
            end else if (w_stop) begin
                r_state   <= S_IDLE;
                r_ack_on  <= 1'b0;
                r_stretch <= 1'b0;
                r_setup   <= '0;
                busy      <= 1'b0;
                stop_det  <= 1'b1;
                scl_o     <= 1'b1;
                sda_o     <= 1'b1;
            end else if (!en && r_state != S_IDLE && r_state != S_WAIT_STOP) begin
                r_state   <= busy ? S_WAIT_STOP : S_IDLE;
                r_stretch <= 1'b0;
                r_setup   <= '0;
                scl_o     <= 1'b1;
                sda_o     <= 1'b1;
            end else begin
                case (r_state)
                    S_ADDR: if (w_scl_rise) begin
                        r_shift  <= w_byte[6:0];
                        r_bitcnt <= r_bitcnt + 3'd1;
                        if (w_last) begin
                            if (w_byte[7:1] == own_addr) begin
                                rw       <= w_byte[0];
                                addr_hit <= 1'b1;
                                r_state  <= S_ADDR_ACK;
                            end else begin
                                r_state <= S_WAIT_STOP;
                            end
                        end
                    end
                    S_ADDR_ACK: if (w_scl_fall) begin
                        if (!r_ack_on) begin
                            sda_o    <= 1'b0;
                            r_ack_on <= 1'b1;
                        end else begin
                            r_ack_on <= 1'b0;
                            sda_o    <= 1'b1;
                            r_bitcnt <= '0;
                            r_state  <= S_RX_BYTE;
                        end
                    end
                    S_RX_BYTE: if (w_scl_rise) begin
                        r_shift  <= w_byte[6:0];
                        r_bitcnt <= r_bitcnt + 3'd1;
                        if (w_last) begin
                            if (!rx_full) begin
                                rx_data <= w_byte;
                                rx_wr   <= 1'b1;
                                r_nack  <= 1'b0;
                            end else begin
                                r_nack <= 1'b1;
                            end
                            r_ack_on <= 1'b0;
                            r_state  <= S_RX_ACK;
                        end
                    end
                    S_RX_ACK: if (w_scl_fall) begin
                        if (!r_ack_on) begin
                            sda_o    <= r_nack;
                            r_ack_on <= 1'b1;
                        end else begin
                            r_ack_on <= 1'b0;
                            sda_o    <= 1'b1;
                            r_state  <= r_nack ? S_WAIT_STOP : S_RX_BYTE;
                        end
                    end
                    S_TX_LOAD: if (r_stretch) begin
                        if (r_setup != 3'd0) begin
                            r_setup <= r_setup - 3'd1;
                            if (r_setup == 3'd1) begin
                                scl_o     <= 1'b1;
                                r_stretch <= 1'b0;
                                r_state   <= S_TX_BYTE;
                            end
                        end else if (!tx_empty) begin
                            r_shift <= tx_data[6:0];
                            sda_o   <= tx_data[7];
                            tx_rd   <= 1'b1;
                            r_setup <= 3'd4;
                        end
                    end
                    S_TX_BYTE: begin
                        if (w_scl_rise) begin
                            r_bitcnt <= r_bitcnt + 3'd1;
                            if (w_last) r_done <= 1'b1;
                        end else if (w_scl_fall) begin
                            if (r_done) begin
                                r_done  <= 1'b0;
                                sda_o   <= 1'b1;
                                r_state <= S_TX_ACK;
                            end else begin
                                sda_o   <= r_shift[6];
                                r_shift <= {r_shift[5:0], 1'b0};
                            end
                        end
                    end
                    S_TX_ACK: if (w_scl_rise) begin
                        if (!w_sda) begin
                            r_state <= S_TX_LOAD;
                        end else begin
                            nack_det <= 1'b1;
                            r_state  <= S_WAIT_STOP;
                        end
                    end
                    default: ;
                endcase
                if (w_load) begin
                    r_bitcnt <= '0;
                    r_done   <= 1'b0;
                    if (!tx_empty) begin
                        r_shift <= tx_data[6:0];
                        sda_o   <= tx_data[7];
                        tx_rd   <= 1'b1;
                        r_state <= S_TX_BYTE;
                    end else if (STRETCH_EN) begin
                        scl_o     <= 1'b0;
                        r_stretch <= 1'b1;
                        r_setup   <= '0;
                        r_state   <= S_TX_LOAD;
                    end else begin
                        r_shift <= 7'h7F;
                        sda_o   <= 1'b1;
                        r_state <= S_TX_BYTE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_core.sv
// Bench for i2c_slave_core: bit-banged bus master, transaction-level expectations, and a
// per-cycle monitor that checks every FIFO handshake and status pulse against them.
module tb_i2c_slave_core;

    localparam int Q = 8;

    logic       PCLK = 1'b0;
    logic       PRESETn, en, rx_full;
    logic [6:0] own_addr;
    logic       m_scl, m_sda;
    logic       scl_bus, sda_bus;
    logic       scl_o, sda_o, tx_rd, rx_wr, busy, rw, addr_hit, stop_det, nack_det;
    logic [7:0] rx_data, tx_data;
    logic       tx_empty;

    logic [7:0] txmem [16];
    int         rp = 0, wp = 0;

    int checks = 0, errors = 0;
    int cnt_hit = 0, cnt_stop = 0, cnt_nack = 0, cnt_txrd = 0;
    int exp_hits = 0, exp_stops = 0, exp_nack = 0, exp_txrd = 0;
    logic       exp_rw = 1'b0;
    logic [7:0] exp_rx [$];
    logic [7:0] rx_log [$];
    logic [7:0] rd_log [$];
    logic       scl_prev = 1'b1, sda_prev = 1'b1;
    logic       ack_v, all_low, bit_v;
    logic [7:0] got;

    always #5 PCLK = ~PCLK;

    assign scl_bus  = m_scl & scl_o;
    assign sda_bus  = m_sda & sda_o;
    assign tx_empty = (wp == rp);
    assign tx_data  = txmem[rp[3:0]];

    i2c_slave_core #(.SYNC_STAGES(2), .STRETCH_EN(1'b1)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .en(en), .own_addr(own_addr),
        .scl_i(scl_bus), .sda_i(sda_bus), .scl_o(scl_o), .sda_o(sda_o),
        .tx_data(tx_data), .tx_empty(tx_empty), .tx_rd(tx_rd),
        .rx_data(rx_data), .rx_full(rx_full), .rx_wr(rx_wr),
        .busy(busy), .rw(rw), .addr_hit(addr_hit), .stop_det(stop_det), .nack_det(nack_det)
    );

    always @(posedge PCLK) if (tx_rd) rp <= rp + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    always @(negedge PCLK) begin
        if (PRESETn) begin
            if (rx_wr) begin
                if (exp_rx.size() == 0) chk("rx_wr_unexpected", rx_wr, 0);
                else                    chk("rx_data", rx_data, exp_rx.pop_front());
                rx_log.push_back(rx_data);
            end
            if (tx_rd) begin
                cnt_txrd++;
                chk("tx_rd_nonempty", tx_empty, 0);
            end
            if (rx_wr || tx_rd) chk("rx_wr_tx_rd_excl", rx_wr & tx_rd, 0);
            if (addr_hit) begin
                cnt_hit++;
                chk("addr_hit_rw", rw, exp_rw);
            end
            if (stop_det) cnt_stop++;
            if (nack_det) cnt_nack++;
            if (scl_bus && scl_prev) chk("sda_stable_scl_hi", sda_o, sda_prev);
        end
        scl_prev = scl_bus;
        sda_prev = sda_o;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge PCLK);
    endtask

    task automatic scl_up();
        int t = 0;
        m_scl = 1'b1;
        while (!scl_bus && t < 2000) begin
            @(negedge PCLK);
            t++;
        end
        chk("scl_release", scl_bus, 1);
    endtask

    task automatic xbit(input logic b, output logic r);
        m_sda = b;
        cyc(Q);
        scl_up();
        cyc(Q);
        r = sda_bus;
        cyc(Q);
        m_scl = 1'b0;
        cyc(Q);
    endtask

    task automatic start_c();
        m_sda = 1'b1;
        cyc(Q);
        scl_up();
        cyc(Q);
        m_sda = 1'b0;
        cyc(Q);
        m_scl = 1'b0;
        cyc(Q);
    endtask

    task automatic stop_c();
        m_sda = 1'b0;
        cyc(Q);
        scl_up();
        cyc(Q);
        m_sda = 1'b1;
        cyc(2 * Q);
    endtask

    task automatic wbyte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) xbit(d[i], r);
        xbit(1'b1, ack);
    endtask

    task automatic rbyte(input logic nack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            xbit(1'b1, r);
            d[i] = r;
        end
        xbit(nack, r);
    endtask

    task automatic ends();
        cyc(4);
        chk("addr_hit_cnt", cnt_hit, exp_hits);
        chk("stop_cnt", cnt_stop, exp_stops);
        chk("nack_cnt", cnt_nack, exp_nack);
        chk("tx_rd_cnt", cnt_txrd, exp_txrd);
        chk("rx_pending", exp_rx.size(), 0);
        chk("busy_idle", busy, 0);
    endtask

    // Transaction-level model: ACK iff address matches with en=1, data ACK iff RX FIFO has room,
    // first refused byte ends the transfer; reads return FIFO bytes in order, last one NACKed.
    task automatic xfer(input logic [6:0] a, input logic rnw, input int n,
                        input logic [23:0] data, input logic [2:0] full);
        logic       ack, match, alive;
        logic [7:0] d, g;
        match = (a == own_addr) && en;
        if (match) begin
            exp_hits++;
            exp_rw = rnw;
        end
        if (rnw && match)
            for (int i = 0; i < n; i++) begin
                txmem[wp[3:0]] = data[8*i +: 8];
                wp++;
            end
        start_c();
        chk("busy_after_start", busy, 1);
        wbyte({a, rnw}, ack);
        chk("addr_ack", ack, !match);
        if (!rnw) begin
            alive = match;
            for (int i = 0; i < n; i++) begin
                d = data[8*i +: 8];
                rx_full = full[i];
                if (alive && !full[i]) exp_rx.push_back(d);
                wbyte(d, ack);
                rx_full = 1'b0;
                chk("data_ack", ack, !(alive && !full[i]));
                if (full[i]) alive = 1'b0;
            end
        end else if (match) begin
            for (int i = 0; i < n; i++) begin
                rbyte(i == n - 1, g);
                rd_log.push_back(g);
                chk("rd_byte", g, data[8*i +: 8]);
                exp_txrd++;
                if (i == n - 1) exp_nack++;
            end
        end
        stop_c();
        exp_stops++;
        ends();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog_timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] a;
        logic [2:0] f;
        PRESETn = 1'b0; en = 1'b1; own_addr = 7'h42; rx_full = 1'b0;
        m_scl = 1'b1; m_sda = 1'b1;
        cyc(3);
        chk("rst_scl_o", scl_o, 1);
        chk("rst_sda_o", sda_o, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rw", rw, 0);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_pulses", {tx_rd, rx_wr, addr_hit, stop_det, nack_det}, 0);
        PRESETn = 1'b1;
        cyc(5);

        // Write 0x84, 0xA5, 0x3C
        rx_log.delete();
        xfer(7'h42, 1'b0, 2, {8'h00, 8'h3C, 8'hA5}, 3'b000);
        chk("wr_rx_count", rx_log.size(), 2);
        if (rx_log.size() == 2) begin
            chk("wr_rx0", rx_log[0], 8'hA5);
            chk("wr_rx1", rx_log[1], 8'h3C);
        end
        chk("wr_hits", cnt_hit, 1);
        chk("wr_rw", rw, 0);

        // Foreign address: ignored until STOP
        rx_log.delete();
        xfer(7'h43, 1'b0, 2, {8'h00, 8'h11, 8'h22}, 3'b000);
        chk("miss_rx_count", rx_log.size(), 0);
        chk("miss_hits", cnt_hit, 1);

        // Read 0x5A, 0xC3; second byte NACKed
        rd_log.delete();
        xfer(7'h42, 1'b1, 2, {8'h00, 8'hC3, 8'h5A}, 3'b000);
        if (rd_log.size() == 2) begin
            chk("rd0", rd_log[0], 8'h5A);
            chk("rd1", rd_log[1], 8'hC3);
        end
        chk("rd_nack_cnt", cnt_nack, 1);
        chk("rd_txrd_cnt", cnt_txrd, 2);

        // Stretch while TX FIFO empty for 200 cycles
        exp_hits++; exp_rw = 1'b1;
        start_c();
        wbyte(8'h85, ack_v);
        chk("str_addr_ack", ack_v, 0);
        fork
            rbyte(1'b1, got);
            begin
                all_low = 1'b1;
                repeat (200) begin
                    @(negedge PCLK);
                    if (scl_o !== 1'b0) all_low = 1'b0;
                end
                chk("stretch_hold", all_low, 1);
                txmem[wp[3:0]] = 8'h77;
                wp++;
            end
        join
        chk("stretch_byte", got, 8'h77);
        exp_txrd++; exp_nack++;
        stop_c();
        exp_stops++;
        ends();

        // RX full -> NACK, then repeated START into a read
        rx_log.delete();
        exp_hits++; exp_rw = 1'b0;
        start_c();
        wbyte(8'h84, ack_v);
        chk("full_addr_ack", ack_v, 0);
        rx_full = 1'b1;
        wbyte(8'h11, ack_v);
        rx_full = 1'b0;
        chk("full_data_nack", ack_v, 1);
        txmem[wp[3:0]] = 8'h99;
        wp++;
        exp_hits++; exp_rw = 1'b1;
        start_c();
        wbyte(8'h85, ack_v);
        chk("rs_addr_ack", ack_v, 0);
        chk("rs_rw", rw, 1);
        rbyte(1'b1, got);
        chk("rs_byte", got, 8'h99);
        exp_txrd++; exp_nack++;
        stop_c();
        exp_stops++;
        ends();
        chk("full_no_rx", rx_log.size(), 0);

        // Reset in the middle of a read byte
        txmem[wp[3:0]] = 8'h0F;
        wp++;
        exp_hits++; exp_rw = 1'b1;
        start_c();
        wbyte(8'h85, ack_v);
        chk("rst_addr_ack", ack_v, 0);
        exp_txrd++;
        xbit(1'b1, bit_v);
        xbit(1'b1, bit_v);
        chk("pre_rst_sda", sda_o, 0);
        PRESETn = 1'b0;
        #1;
        chk("mid_rst_sda", sda_o, 1);
        chk("mid_rst_scl", scl_o, 1);
        chk("mid_rst_busy", busy, 0);
        m_sda = 1'b1;
        cyc(2);
        m_scl = 1'b1;
        exp_rw = 1'b0;
        cyc(5);
        PRESETn = 1'b1;
        cyc(5);
        xfer(7'h42, 1'b0, 1, {16'h0, 8'h5C}, 3'b000);

        // Randomized transactions
        for (int k = 0; k < 20; k++) begin
            own_addr = 7'($urandom_range(0, 127));
            en = ($urandom_range(0, 9) != 0);
            a = ($urandom_range(0, 1) != 0) ? own_addr : own_addr ^ 7'($urandom_range(1, 127));
            f = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
            xfer(a, 1'($urandom_range(0, 1)), $urandom_range(1, 3), 24'($urandom), f);
        end
        en = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
